// File: rtl/vga_dls_pkg.sv
// vga_dls_pkg: shared types, widths and the bitwise majority helper for the NMR voter
package vga_dls_pkg;
  localparam int CTRL_W = 35;
  typedef enum logic [1:0] {OK, SUSPECT, FAULT} nmr_state_e;
  typedef struct packed {
    logic        hreadyout;
    logic [31:0] hrdata;
    logic [7:0]  rgb;
    logic        vsync;
    logic        hsync;
  } vga_bundle_t;
  // ties (even channel count) resolve to the primary bit v[0]
  function automatic logic majority(input logic [6:0] v, input int n);
    int c;
    c = 0;
    for (int i = 0; i < 7; i++) c += (i < n) ? int'(v[i]) : 0;
    return (2 * c == n) ? v[0] : (2 * c > n);
  endfunction
endpackage

// File: rtl/dls_delay_line.sv
// dls_delay_line: sync-reset shift register with a valid flag that rises once the line has filled
module dls_delay_line #(
  parameter int WIDTH = 8,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  logic [DELAY:0] v;
  always_ff @(posedge clk) v <= rst ? '0 : (v << 1) | (DELAY+1)'(1);
  assign vld = v[DELAY];
  if (DELAY == 0) begin : g_pass
    assign q = d;
  end else if (DELAY == 1) begin : g_one
    always_ff @(posedge clk) q <= rst ? '0 : d;
  end else begin : g_line
    logic [DELAY-1:0][WIDTH-1:0] sr;
    always_ff @(posedge clk) sr <= rst ? '0 : {sr[DELAY-2:0], d};
    assign q = sr[DELAY-1];
  end
endmodule

// File: rtl/ahb_vga_nmr_voter.sv
// ahb_vga_nmr_voter: aligns a primary against shadow VGA/AHB channels, compares or votes, filters faults
module ahb_vga_nmr_voter
  import vga_dls_pkg::*;
#(
  parameter int NCH    = 3,
  parameter int RGB_W  = 8,
  parameter int DELAY  = 2,
  parameter int THRESH = 2,
  parameter int CNT_W  = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NCH-1:0]       ch_hsync,
  input  logic [NCH-1:0]       ch_vsync,
  input  logic [NCH*RGB_W-1:0] ch_rgb,
  input  logic [NCH*32-1:0]    ch_hrdata,
  input  logic [NCH-1:0]       ch_hreadyout,
  input  logic                 mode,
  input  logic                 err_clear,
  output logic                 HSYNC,
  output logic                 VSYNC,
  output logic [RGB_W-1:0]     RGB,
  output logic [31:0]          HRDATA,
  output logic                 HREADYOUT,
  output logic                 DLS_ERROR,
  output logic [NCH-1:0]       fault_mask,
  output logic [CNT_W-1:0]     err_count
);
  localparam int W = CTRL_W + RGB_W;
  logic [NCH-1:0][W-1:0] raw, b;
  logic [W-1:0] prim_d, vote, sel;
  logic [NCH-1:0] diff;
  logic vld, vmode, mismatch;
  nmr_state_e st, st_n;
  logic [3:0] run, run_n;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign raw[k] = {ch_hreadyout[k], ch_hrdata[k*32 +: 32], ch_rgb[k*RGB_W +: RGB_W], ch_vsync[k], ch_hsync[k]};
  end
  dls_delay_line #(.WIDTH(W), .DELAY(DELAY)) u_dl (
    .clk(HCLK), .rst(HRESET), .d(raw[0]), .q(prim_d), .vld(vld)
  );
  assign vmode = mode && (NCH >= 3);
  always_comb begin
    logic [6:0] col;
    b = raw;
    b[0] = prim_d;
    vote = '0;
    col = '0;
    for (int j = 0; j < W; j++) begin
      col = '0;
      for (int k = 0; k < NCH; k++) col[k] = b[k][j];
      vote[j] = majority(col, NCH);
    end
    sel = vmode ? vote : prim_d;
    diff = '0;
    for (int k = 0; k < NCH; k++) diff[k] = vld && (b[k] != sel);
    mismatch = |diff;
  end
  always_comb begin
    st_n = st;
    run_n = run;
    if (err_clear) begin
      st_n = OK;
      run_n = '0;
    end else if (st != FAULT) begin
      run_n = mismatch ? run + 4'd1 : '0;
      st_n = !mismatch ? OK : (run_n >= 4'(THRESH)) ? FAULT : SUSPECT;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      {HREADYOUT, HRDATA, RGB, VSYNC, HSYNC} <= {1'b1, (W-1)'(0)};
      st <= OK;
      run <= '0;
      DLS_ERROR <= 1'b0;
      fault_mask <= '0;
      err_count <= '0;
    end else begin
      {HREADYOUT, HRDATA, RGB, VSYNC, HSYNC} <= sel;
      st <= st_n;
      run <= run_n;
      DLS_ERROR <= st_n == FAULT;
      fault_mask <= err_clear ? '0 : fault_mask | diff;
      err_count <= err_count + CNT_W'(st != FAULT && st_n == FAULT && !(&err_count));
    end
  end
endmodule

// File: tb/tb_ahb_vga_nmr_voter.sv
// tb_ahb_vga_nmr_voter: directed scoreboard bench for the NMR voter (default and 2-bit counter builds)
module tb_ahb_vga_nmr_voter;
  typedef struct packed {
    logic        hr;
    logic [31:0] hrdata;
    logic [7:0]  rgb;
    logic        vs;
    logic        hs;
  } p_t;
  typedef struct {
    bit         rst_cyc;
    bit         chk_out;
    p_t         out;
    logic       err;
    logic [2:0] mask;
    logic [7:0] cnt;
    logic [1:0] sat;
  } exp_t;

  logic HCLK = 0, HRESET, mode, err_clear;
  logic [2:0] ch_hsync, ch_vsync, ch_hreadyout;
  logic [23:0] ch_rgb;
  logic [95:0] ch_hrdata;
  logic HSYNC, VSYNC, HREADYOUT, DLS_ERROR;
  logic [7:0] RGB, err_count;
  logic [31:0] HRDATA;
  logic [2:0] fault_mask;
  logic s_hs, s_vs, s_hr, s_err;
  logic [7:0] s_rgb;
  logic [31:0] s_hrd;
  logic [2:0] s_mask;
  logic [1:0] s_cnt;

  exp_t q[$];
  int n_chk = 0, n_fail = 0, g = 0, sr = 0;

  always #5 HCLK = ~HCLK;

  ahb_vga_nmr_voter dut (
    .HCLK(HCLK), .HRESET(HRESET), .ch_hsync(ch_hsync), .ch_vsync(ch_vsync), .ch_rgb(ch_rgb),
    .ch_hrdata(ch_hrdata), .ch_hreadyout(ch_hreadyout), .mode(mode), .err_clear(err_clear),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .DLS_ERROR(DLS_ERROR), .fault_mask(fault_mask), .err_count(err_count)
  );

  ahb_vga_nmr_voter #(.CNT_W(2)) dut_sat (
    .HCLK(HCLK), .HRESET(HRESET), .ch_hsync(ch_hsync), .ch_vsync(ch_vsync), .ch_rgb(ch_rgb),
    .ch_hrdata(ch_hrdata), .ch_hreadyout(ch_hreadyout), .mode(mode), .err_clear(err_clear),
    .HSYNC(s_hs), .VSYNC(s_vs), .RGB(s_rgb), .HRDATA(s_hrd), .HREADYOUT(s_hr),
    .DLS_ERROR(s_err), .fault_mask(s_mask), .err_count(s_cnt)
  );

  function automatic p_t prim(input int n);
    logic [31:0] u;
    p_t p;
    u = n;
    p.hs = u[2];
    p.vs = u[5];
    p.hr = ~u[0];
    p.rgb = {1'b0, u[6:0]};
    p.hrdata = (u * 32'h0101_0101) ^ 32'hA5A5_0000;
    return p;
  endfunction

  // r: reset, m: mode, clr: err_clear, c1h/c1d: flip ch1 hsync / hrdata[0], c2f: ch2 rgb stuck at FF
  task automatic step(input bit r, input bit m, input bit clr, input bit c1h, input bit c1d, input bit c2f,
                      input bit e_err, input logic [2:0] e_mask, input int e_cnt);
    p_t p, s;
    exp_t e;
    p = prim(g);
    s = prim(g - 2);
    HRESET = r;
    mode = m;
    err_clear = clr;
    ch_hsync = {s.hs, s.hs ^ c1h, p.hs};
    ch_vsync = {s.vs, s.vs, p.vs};
    ch_rgb = {c2f ? 8'hFF : s.rgb, s.rgb, p.rgb};
    ch_hrdata = {s.hrdata, s.hrdata ^ {31'b0, c1d}, p.hrdata};
    ch_hreadyout = {s.hr, s.hr, p.hr};
    @(posedge HCLK);
    #1;
    sr = r ? 0 : sr + 1;
    e.rst_cyc = r;
    e.chk_out = !r && sr >= 3;
    e.out = prim(g - 2);
    e.err = e_err;
    e.mask = e_mask;
    e.cnt = 8'(e_cnt);
    e.sat = e_cnt > 3 ? 2'd3 : 2'(e_cnt);
    q.push_back(e);
    g++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    p_t act;
    forever begin
      @(negedge HCLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {HREADYOUT, HRDATA, RGB, VSYNC, HSYNC};
        if (e.rst_cyc) chk("reset_outputs", 64'(act), 64'({1'b1, 42'b0}));
        else if (e.chk_out) chk("outputs", 64'(act), 64'(e.out));
        chk("dls_error", 64'(DLS_ERROR), 64'(e.err));
        chk("fault_mask", 64'(fault_mask), 64'(e.mask));
        chk("err_count", 64'(err_count), 64'(e.cnt));
        chk("err_count_sat", 64'(s_cnt), 64'(e.sat));
      end
    end
  end

  initial begin
    HRESET = 1;
    mode = 0;
    err_clear = 0;
    ch_hsync = '0;
    ch_vsync = '0;
    ch_rgb = '0;
    ch_hrdata = '0;
    ch_hreadyout = '0;
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    repeat (1000) step(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    // vote mode, ch2 RGB stuck: outputs stay on the primary, FAULT after two cycles
    step(0, 1, 0, 0, 0, 1, 0, 3'b100, 0);
    step(0, 1, 0, 0, 0, 1, 1, 3'b100, 1);
    step(0, 1, 0, 0, 0, 1, 1, 3'b100, 1);
    step(0, 1, 1, 0, 0, 0, 0, 3'b000, 1);
    // single-cycle HRDATA glitch on ch1 is filtered
    step(0, 1, 0, 0, 1, 0, 0, 3'b010, 1);
    step(0, 1, 0, 0, 0, 0, 0, 3'b010, 1);
    step(0, 1, 0, 0, 0, 0, 0, 3'b010, 1);
    step(0, 1, 1, 0, 0, 0, 0, 3'b000, 1);
    // compare mode, persistent ch1 HSYNC mismatch; clear wins over the live mismatch
    step(0, 0, 0, 1, 0, 0, 0, 3'b010, 1);
    step(0, 0, 0, 1, 0, 0, 1, 3'b010, 2);
    step(0, 0, 0, 1, 0, 0, 1, 3'b010, 2);
    step(0, 0, 1, 1, 0, 0, 0, 3'b000, 2);
    step(0, 0, 0, 1, 0, 0, 0, 3'b010, 2);
    step(0, 0, 0, 1, 0, 0, 1, 3'b010, 3);
    step(0, 0, 1, 0, 0, 0, 0, 3'b000, 3);
    // repeated fault/clear cycles: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 1, 0, 3'b100, 3 + i);
      step(0, 1, 0, 0, 0, 1, 1, 3'b100, 4 + i);
      step(0, 1, 1, 0, 0, 0, 0, 3'b000, 4 + i);
    end
    // reset in the middle of FAULT, then shadows disagree only during warm-up
    step(0, 1, 0, 0, 0, 1, 0, 3'b100, 8);
    step(0, 1, 0, 0, 0, 1, 1, 3'b100, 9);
    step(1, 1, 0, 0, 0, 1, 0, 3'b000, 0);
    repeat (3) step(0, 0, 0, 1, 0, 1, 0, 3'b000, 0);
    repeat (10) step(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge HCLK);
    #2;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
